// File: rtl/fc12_pkg.sv
// fc12_pkg: shared sizes, beat-counter width and signed word type for the fc12 binary-weight layer
package fc12_pkg;
  localparam int LANES  = 12;
  localparam int DATA_W = 32;
  localparam int BEATS  = 16;
  localparam int N_IN   = LANES * BEATS;
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction
  localparam int CNT_W = cnt_width(BEATS);
  typedef logic signed [DATA_W-1:0] word_t;
endpackage

// File: rtl/fc12_lane_sum.sv
// fc12_lane_sum: conditional negation of 12 lanes by their 1-bit weights and a signed adder tree
module fc12_lane_sum
  import fc12_pkg::*;
#(
  parameter int DATA_W = fc12_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] din [LANES],
  input  logic        [LANES-1:0]  w,
  output logic signed [DATA_W-1:0] sum
);
  logic signed [DATA_W-1:0] term [LANES];
  logic signed [DATA_W-1:0] l1 [LANES/2];
  logic signed [DATA_W-1:0] l2 [LANES/4];
  genvar i;
  // weight 1 passes the activation, weight 0 negates it
  for (i = 0; i < LANES; i++) begin : g_term
    always_comb term[i] = w[i] ? din[i] : -din[i];
  end
  // pairwise first level, 12 -> 6
  for (i = 0; i < LANES/2; i++) begin : g_l1
    always_comb l1[i] = term[2*i] + term[2*i+1];
  end
  // second level, 6 -> 3
  for (i = 0; i < LANES/4; i++) begin : g_l2
    always_comb l2[i] = l1[2*i] + l1[2*i+1];
  end
  // final three-input add, wrapping at DATA_W bits
  always_comb sum = l2[0] + l2[1] + l2[2];
endmodule

// File: rtl/fc12_layer.sv
// fc12_layer: binary-weight fully connected neuron, 12 lanes x BEATS beats; FC12_PIPE_EN adds a register after the adder tree
module fc12_layer
  import fc12_pkg::*;
#(
  parameter int DATA_W = fc12_pkg::DATA_W,
  parameter int BEATS  = fc12_pkg::BEATS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ivalid,
  input  logic signed [DATA_W-1:0] din_0,
  input  logic signed [DATA_W-1:0] din_1,
  input  logic signed [DATA_W-1:0] din_2,
  input  logic signed [DATA_W-1:0] din_3,
  input  logic signed [DATA_W-1:0] din_4,
  input  logic signed [DATA_W-1:0] din_5,
  input  logic signed [DATA_W-1:0] din_6,
  input  logic signed [DATA_W-1:0] din_7,
  input  logic signed [DATA_W-1:0] din_8,
  input  logic signed [DATA_W-1:0] din_9,
  input  logic signed [DATA_W-1:0] din_10,
  input  logic signed [DATA_W-1:0] din_11,
  input  logic                     weight,
  input  logic                     weight_en,
  output logic                     ovalid,
  output logic signed [DATA_W-1:0] dout
);
  localparam int NW = LANES * BEATS;
  localparam int CW = cnt_width(BEATS);
  logic        [NW-1:0]     store;
  logic        [CW-1:0]     cnt;
  logic                     last;
  logic        [LANES-1:0]  wsel;
  logic signed [DATA_W-1:0] lanes [LANES];
  logic signed [DATA_W-1:0] partial;
  logic signed [DATA_W-1:0] acc;
  logic                     s_valid;
  logic                     s_last;
  logic signed [DATA_W-1:0] s_partial;
  // gather the lane ports and pick this beat's 12 weights
  always_comb begin
    lanes[0]  = din_0;
    lanes[1]  = din_1;
    lanes[2]  = din_2;
    lanes[3]  = din_3;
    lanes[4]  = din_4;
    lanes[5]  = din_5;
    lanes[6]  = din_6;
    lanes[7]  = din_7;
    lanes[8]  = din_8;
    lanes[9]  = din_9;
    lanes[10] = din_10;
    lanes[11] = din_11;
    last      = cnt == CW'(BEATS - 1);
    wsel      = store[cnt*LANES +: LANES];
  end
  fc12_lane_sum #(.DATA_W(DATA_W)) u_sum (
    .din (lanes),
    .w   (wsel),
    .sum (partial)
  );
  // serial weight store: bits enter at the top, so after NW loads the first bit sits at element 0
  always_ff @(posedge clk or posedge rst)
    if (rst) store <= '0;
    else if (weight_en) store <= {weight, store[NW-1:1]};
  // beat counter selects the weight slice; weight loading abandons the current frame
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (weight_en) cnt <= '0;
    else if (ivalid) cnt <= last ? '0 : cnt + 1'b1;
`ifdef FC12_PIPE_EN
  // register after the adder tree, carrying the beat-valid and last-beat flags along
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_valid   <= 1'b0;
      s_last    <= 1'b0;
      s_partial <= '0;
    end else begin
      s_valid   <= ivalid & ~weight_en;
      s_last    <= last;
      s_partial <= partial;
    end
`else
  // no pipeline register: the accumulate stage sees the tree output directly
  always_comb begin
    s_valid   = ivalid & ~weight_en;
    s_last    = last;
    s_partial = partial;
  end
`endif
  // accumulate partials, publish on the last beat and restart for the next frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc    <= '0;
      dout   <= '0;
      ovalid <= 1'b0;
    end else begin
      ovalid <= s_valid & s_last & ~weight_en;
      if (weight_en) acc <= '0;
      else if (s_valid) begin
        acc <= s_last ? '0 : acc + s_partial;
        if (s_last) dout <= acc + s_partial;
      end
    end
endmodule

// File: tb/tb_fc12_layer.sv
// tb_fc12_layer: randomized and directed checks of fc12_layer against a frame-level dot-product model
module tb_fc12_layer;
  import fc12_pkg::*;
`ifdef FC12_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1, ivalid = 0, weight = 0, weight_en = 0;
  word_t din [LANES];
  logic ovalid;
  word_t dout;
  int tests = 0, fails = 0, pulses = 0;
  bit wq[$];
  word_t elems [N_IN];
  int m_beat;
  bit hf[$];
  word_t hv[$];
  word_t exp_dout;

  fc12_layer dut (
    .clk(clk), .rst(rst), .ivalid(ivalid),
    .din_0(din[0]), .din_1(din[1]), .din_2(din[2]), .din_3(din[3]),
    .din_4(din[4]), .din_5(din[5]), .din_6(din[6]), .din_7(din[7]),
    .din_8(din[8]), .din_9(din[9]), .din_10(din[10]), .din_11(din[11]),
    .weight(weight), .weight_en(weight_en), .ovalid(ovalid), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    for (int k = 0; k < N_IN; k++) wq.push_back(1'b0);
    m_beat = 0;
    hf.delete();
    hv.delete();
    exp_dout = 0;
  endtask

  task automatic tick(input bit v, input bit we, input bit wb);
    bit f, ef;
    word_t s, ev;
    ivalid = v;
    weight_en = we;
    weight = wb;
    @(posedge clk);
    f = 0;
    s = 0;
    if (we) begin
      wq.push_back(wb);
      void'(wq.pop_front());
      m_beat = 0;
      if (hf.size() > 0) hf[0] = 0;
    end else if (v) begin
      for (int l = 0; l < LANES; l++) elems[LANES*m_beat+l] = din[l];
      if (m_beat == BEATS - 1) begin
        for (int k = 0; k < N_IN; k++) s += wq[k] ? elems[k] : -elems[k];
        f = 1;
        m_beat = 0;
      end else m_beat++;
    end
    hf.push_back(f);
    hv.push_back(s);
    ef = 0;
    if (hf.size() == LAT) begin
      ef = hf.pop_front();
      ev = hv.pop_front();
      if (ef) exp_dout = ev;
    end
    #1;
    if (ovalid) pulses++;
    check("ovalid", {31'b0, ovalid}, {31'b0, ef});
    check("dout", dout, exp_dout);
  endtask

  task automatic load(input int mode);
    for (int k = 0; k < N_IN; k++)
      tick(0, 1, mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? ~k[0] : 1'($urandom));
  endtask

  task automatic set_din(input int mode);
    for (int l = 0; l < LANES; l++)
      din[l] = mode == 0 ? 32'sd1 : mode == 1 ? 32'(l) : mode == 2 ? 32'h7FFFFFFF : word_t'($urandom);
  endtask

  task automatic frame(input int mode, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      set_din(mode);
      tick(1, 0, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_dout", dout, 0);
    check("rst_ovalid", {31'b0, ovalid}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int p0;
    model_reset();
    set_din(0);
    repeat (2) @(posedge clk);
    #1;
    check("init_dout", dout, 0);
    check("init_ovalid", {31'b0, ovalid}, 0);
    rst = 0;
    load(1);
    frame(0, BEATS);
    repeat (2) tick(0, 0, 0);
    check("allpos", dout, 192);
    frame(0, 5);
    do_reset();
    load(1);
    frame(0, BEATS);
    repeat (2) tick(0, 0, 0);
    check("after_rst", dout, 192);
    load(0);
    frame(0, BEATS);
    repeat (2) tick(0, 0, 0);
    check("allneg", dout, -192);
    load(2);
    frame(1, BEATS);
    repeat (2) tick(0, 0, 0);
    check("alt", dout, -96);
    load(1);
    p0 = pulses;
    frame(0, 8);
    repeat (3) tick(0, 0, 0);
    frame(0, 8);
    frame(0, BEATS);
    repeat (3) tick(0, 0, 0);
    check("gap_pulses", pulses - p0, 2);
    check("gap_dout", dout, 192);
    frame(2, BEATS);
    repeat (2) tick(0, 0, 0);
    check("wrap", dout, -192);
    p0 = pulses;
    frame(0, 5);
    tick(0, 1, 1);
    frame(0, 11);
    repeat (3) tick(0, 0, 0);
    check("abort_pulses", pulses - p0, 0);
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        load(3);
        if ($urandom_range(0, 2) == 0)
          repeat ($urandom_range(1, 20)) tick(0, 1, 1'($urandom));
      end
      for (int fr = 0; fr < 2 * BEATS; fr++) begin
        set_din($urandom_range(0, 3) == 0 ? 1 : 3);
        if ($urandom_range(0, 60) == 0) tick(0, 1, 1'($urandom));
        else if ($urandom_range(0, 4) == 0) tick(0, 0, 0);
        else tick($urandom_range(0, 5) != 0, 0, 0);
      end
    end
    repeat (3) tick(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
